dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
- Shares the single data-memory port (dm_4k) between two requesters: port 0 = CPU load/store path, port 1 = debug/DMA loader (program/data preload, memory dump).
- Sits between the ALU-address/routb store path and the dm instance.
- Issues at most one access per cycle. Read data and ack are registered one cycle after issue.
- Uses fixed CPU priority with a starvation counter that guarantees the loader forward progress. Drives a CPU stall while the CPU is waiting.

Parameters:
- AW, 12, byte address width (4 KiB data memory)
- DW, 32, data width
- MAX_WAIT, 4, consecutive cycles an eligible loader request may lose before it is forced to win (range 1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- c_req  in  1  CPU access request; held until c_ack
- c_we  in  1  CPU write (1) / read (0)
- c_bext  in  2  CPU byte/half/word mode; passes through to memory byteExt
- c_addr  in  AW  CPU byte address
- c_wdata  in  DW  CPU store data
- c_ack  out  1  CPU access completed (one-cycle pulse)
- c_rdata  out  DW  CPU read data, valid while c_ack=1
- c_stall  out  1  CPU must hold its PC/pipeline this cycle
- l_req, l_we, l_bext, l_addr, l_wdata  in  1/1/2/AW/DW  loader request fields; same rules as the CPU fields
- l_ack  out  1  loader access completed
- l_rdata  out  DW  loader read data, valid while l_ack=1
- m_addr  out  AW  to dm addr
- m_din  out  DW  to dm din
- m_bext  out  2  to dm byteExt
- m_wEn  out  1  to dm wEn (write enable)
- m_dout  in  DW  dm combinational read data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named rst.
- Reset values: c_ack=0, l_ack=0, c_rdata=0, l_rdata=0, wait_cnt=0, busy_c=0, busy_l=0.
- Reset mid-operation: an in-flight access is dropped and no ack is generated. A write issued in the same cycle as rst is blocked (m_wEn forced 0 while rst=1).
- Eligibility:
  - Port eligible = req & ~busy.
  - busy_x is set the cycle after port x is issued and cleared one cycle later. This prevents double-issue while req is still high during the ack cycle.
  - Each port therefore gets at most one access per 2 cycles. The other port may use the intervening cycle.
- Grant (combinational within cycle t):
  - Loader wins if loader is eligible and (CPU not eligible, or wait_cnt==MAX_WAIT).
  - Otherwise CPU wins if eligible.
  - Otherwise idle.
- Issue in cycle t:
  - m_addr/m_din/m_bext come from the granted port; m_wEn = granted_we.
  - When idle: m_wEn=0 and m_addr/m_din/m_bext=0.
- Completion in cycle t+1:
  - Granted port's ack=1.
  - rdata = m_dout registered at the end of cycle t for reads. For writes, rdata holds its previous value.
  - Latency is exactly 1 cycle from issue to ack.
- Stall: c_stall = c_req & ~c_ack. This is combinational, so the CPU is stalled from request until the ack cycle inclusive-exclusive (stall falls in the ack cycle).
- Starvation counter (wait_cnt, 4 bits, saturates at MAX_WAIT):
  - Increments when loader is eligible and not granted.
  - Clears when loader is granted or l_req=0.
  - Holds when loader is busy.
- Simultaneous events:
  - Both eligible with wait_cnt<MAX_WAIT: CPU wins and wait_cnt increments.
  - At MAX_WAIT: loader wins, wait_cnt clears, and the CPU stays stalled one more cycle.
- Same-address hazard: loader write then CPU read of the same address in the next cycle returns the new data (memory write commits at the clock edge of issue).
- Requester rule: request fields must stay stable while req=1 and no ack. Behaviour on changing them is undefined (no checking in RTL; the bench asserts it).
- No combinational path from m_dout to any output other than through the rdata registers.

Decomposition:
- Shared package dm_arb_pkg:
  - port index constants PORT_CPU=0, PORT_LDR=1
  - byteExt encodings BEXT_WORD/BEXT_HALF/BEXT_BYTE (same values as dm)
  - grant enum {GNT_NONE, GNT_CPU, GNT_LDR}
- Single sub-module arb_starve_cnt: saturating wait counter with inc/clr/hold inputs and an at_max output.
- Everything else is flat.

Test Plan:
- Reset: assert rst 2 cycles with both reqs high. Expect no acks, m_wEn=0, rdata=0. First grant goes to the CPU in the cycle after rst falls.
- CPU-only: write 0xDEADBEEF to 0x010 (word), then read 0x010. Expect c_ack one cycle after each issue, c_rdata=0xDEADBEEF, and c_stall high exactly 1 cycle per access.
- Loader-only burst: l_req held continuously over addresses 0x000..0x01C. Expect l_ack every 2nd cycle and 8 acks in 16 cycles.
- Contention with MAX_WAIT=4: both requesting continuously. Expect grant pattern CPU,(busy) …; loader granted no later than its 5th eligible cycle, with wait_cnt resetting to 0 after that grant.
- Simultaneous request: loader write 0x12345678 @0x020 forced by starvation in cycle t, CPU read @0x020 granted t+1. Expect c_rdata=0x12345678.
- Reset mid-operation: rst asserted the cycle after a CPU read is issued. Expect no c_ack, c_rdata=0, and the memory location unchanged.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: port indices, dm byteExt
// encodings and the per-cycle grant type.
package dm_arb_pkg;

  localparam int unsigned PORT_CPU = 0;
  localparam int unsigned PORT_LDR = 1;
  localparam int unsigned NPORTS   = 2;

  localparam int unsigned WAIT_CNT_W = 4;

  localparam logic [1:0] BEXT_WORD = 2'b00;
  localparam logic [1:0] BEXT_HALF = 2'b01;
  localparam logic [1:0] BEXT_BYTE = 2'b10;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_LDR  = 2'd2
  } gnt_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating loader wait counter: counts cycles an eligible loader request
// loses arbitration, clears on grant or request drop, holds otherwise.
module arb_starve_cnt
  import dm_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_inc,
  input  logic                  i_clr,
  output logic [WAIT_CNT_W-1:0] o_cnt,
  output logic                  o_at_max
);

  localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MAX_WAIT);

  logic [WAIT_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_CNT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt    = r_cnt;
  assign o_at_max = (r_cnt == MAX_CNT);

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter for the single dm_4k port: CPU has fixed priority, the
// loader is protected from starvation, one access per cycle, 1-cycle ack.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned AW       = 12,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [1:0]    c_bext,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [1:0]    l_bext,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_ack,
  output logic [DW-1:0] l_rdata,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_din,
  output logic [1:0]    m_bext,
  output logic          m_wEn,
  input  logic [DW-1:0] m_dout
);

  logic [NPORTS-1:0]     r_busy;
  logic [NPORTS-1:0]     r_ack;
  logic [DW-1:0]         r_c_rdata;
  logic [DW-1:0]         r_l_rdata;

  logic                  w_c_elig;
  logic                  w_l_elig;
  logic                  w_at_max;
  logic                  w_cnt_inc;
  logic                  w_cnt_clr;
  logic [WAIT_CNT_W-1:0] w_wait_cnt;
  logic                  w_we;
  gnt_e                  w_gnt;

  assign w_c_elig = c_req & ~r_busy[PORT_CPU];
  assign w_l_elig = l_req & ~r_busy[PORT_LDR];

  always_comb begin
    w_gnt = GNT_NONE;
    if (w_l_elig && (!w_c_elig || w_at_max)) begin
      w_gnt = GNT_LDR;
    end else if (w_c_elig) begin
      w_gnt = GNT_CPU;
    end
  end

  always_comb begin
    m_addr = '0;
    m_din  = '0;
    m_bext = BEXT_WORD;
    w_we   = 1'b0;
    case (w_gnt)
      GNT_CPU: begin
        m_addr = c_addr;
        m_din  = c_wdata;
        m_bext = c_bext;
        w_we   = c_we;
      end
      GNT_LDR: begin
        m_addr = l_addr;
        m_din  = l_wdata;
        m_bext = l_bext;
        w_we   = l_we;
      end
      default: ;
    endcase
  end

  assign m_wEn = w_we & ~rst;

  assign w_cnt_inc = w_l_elig & (w_gnt != GNT_LDR);
  assign w_cnt_clr = (w_gnt == GNT_LDR) | ~l_req;

  arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (w_cnt_inc),
    .i_clr    (w_cnt_clr),
    .o_cnt    (w_wait_cnt),
    .o_at_max (w_at_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= '0;
      r_ack     <= '0;
      r_c_rdata <= '0;
      r_l_rdata <= '0;
    end else begin
      r_busy[PORT_CPU] <= (w_gnt == GNT_CPU);
      r_busy[PORT_LDR] <= (w_gnt == GNT_LDR);
      r_ack[PORT_CPU]  <= (w_gnt == GNT_CPU);
      r_ack[PORT_LDR]  <= (w_gnt == GNT_LDR);
      if ((w_gnt == GNT_CPU) && !c_we) begin
        r_c_rdata <= m_dout;
      end
      if ((w_gnt == GNT_LDR) && !l_we) begin
        r_l_rdata <= m_dout;
      end
    end
  end

  // Acks are masked while rst is high so an access issued just before reset
  // never completes, even though its ack register was already loaded.
  assign c_ack   = r_ack[PORT_CPU] & ~rst;
  assign l_ack   = r_ack[PORT_LDR] & ~rst;
  assign c_rdata = r_c_rdata;
  assign l_rdata = r_l_rdata;
  assign c_stall = c_req & ~c_ack;

endmodule
